// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin front end for a single SDRAM engine.
// Each port posts one-cycle start pulses; the arbiter latches them as pending
// requests, grants one port at a time, forwards the engine's word strobes,
// completion and read data to the owner, and aborts transfers that stall.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT = 16777216
) (
  input  logic        clk,
  input  logic        rst,
  // port 0
  input  logic        p0_start,
  input  logic        p0_rnw,
  input  logic [15:0] p0_wdat,
  output logic        p0_done,
  output logic        p0_ready,
  output logic        p0_abort,
  // port 1
  input  logic        p1_start,
  input  logic        p1_rnw,
  input  logic [15:0] p1_wdat,
  output logic        p1_done,
  output logic        p1_ready,
  output logic        p1_abort,
  // shared read data
  output logic [15:0] rdat,
  // SDRAM engine side
  output logic        dram_start,
  output logic        dram_rnw,
  output logic [15:0] dram_wdat,
  input  logic        dram_done,
  input  logic        dram_ready,
  input  logic [15:0] dram_rdat,
  // statistics
  output logic [15:0] abort_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY,
    ST_RELEASE
  } state_t;

  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

  state_t      state_q, state_d;
  // grant_q names the owner during a transfer and doubles as the last-grant
  // memory for round-robin, so it resets to port 1 to let port 0 win first.
  logic        grant_q, grant_d;
  logic [1:0]  pend_q;     // request waiting for service
  logic [1:0]  rearm_q;    // new request posted by the owner mid-transfer
  logic [1:0]  rnw_q;      // direction captured with the request
  logic [31:0] busy_cnt_q; // BUSY cycles elapsed, 0 in the first BUSY cycle
  logic [15:0] abort_cnt_q;

  logic [1:0]  start_v, rnw_in;
  logic        is_busy, done_ok, time_hit, xfer_end, abort_hit;

  assign start_v = {p1_start, p0_start};
  assign rnw_in  = {p1_rnw, p0_rnw};

  // The engine's done line idles high, so it only counts from the second
  // BUSY cycle onward; a timeout ends the transfer as an abort unless the
  // engine finished in the very same cycle.
  assign is_busy   = (state_q == ST_BUSY);
  assign done_ok   = is_busy && dram_done && (busy_cnt_q != 32'd0);
  assign time_hit  = is_busy && (busy_cnt_q >= TIMEOUT_C);
  assign xfer_end  = done_ok || time_hit;
  assign abort_hit = time_hit && !done_ok;

  assign rdat        = dram_rdat;
  assign dram_wdat   = grant_q ? p1_wdat : p0_wdat;
  assign dram_rnw    = rnw_q[grant_q];
  assign abort_count = abort_cnt_q;

  // State and grant registers.
  always_ff @(posedge clk) begin
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state, arbitration and port-facing strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    dram_start = 1'b0;
    p0_ready   = 1'b0;
    p1_ready   = 1'b0;
    p0_done    = 1'b0;
    p1_done    = 1'b0;
    p0_abort   = 1'b0;
    p1_abort   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d = ST_GRANT;
          // Both waiting: hand it to the port that was not served last.
          grant_d = (&pend_q) ? ~grant_q : pend_q[1];
        end
      end
      ST_GRANT:   state_d = ST_BUSY;
      ST_BUSY:    if (xfer_end) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Outputs are forced quiet while reset is held, even though the state
    // register only clears on the next edge.
    if (!rst) begin
      dram_start = (state_q == ST_GRANT);
      p0_ready   = is_busy && dram_ready && !grant_q;
      p1_ready   = is_busy && dram_ready &&  grant_q;
      p0_done    = xfer_end  && !grant_q;
      p1_done    = xfer_end  &&  grant_q;
      p0_abort   = abort_hit && !grant_q;
      p1_abort   = abort_hit &&  grant_q;
    end
  end

  // Per-port request capture. A start is ignored while that port already has
  // a request outstanding, except that the owner may post its next request
  // once its transfer is under way; that request survives RELEASE.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 2'b00;
      rearm_q <= 2'b00;
      rnw_q   <= 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (state_q == ST_RELEASE && grant_q == 1'(n)) begin
          pend_q[n]  <= rearm_q[n] | start_v[n];
          rearm_q[n] <= 1'b0;
          if (start_v[n] && !rearm_q[n]) rnw_q[n] <= rnw_in[n];
        end else if (state_q == ST_BUSY && grant_q == 1'(n)) begin
          if (start_v[n] && !rearm_q[n]) begin
            rearm_q[n] <= 1'b1;
            rnw_q[n]   <= rnw_in[n];
          end
        end else if (start_v[n] && !pend_q[n]) begin
          pend_q[n] <= 1'b1;
          rnw_q[n]  <= rnw_in[n];
        end
      end
    end
  end

  // BUSY-cycle counter: zeroed on the way into BUSY, counts while in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= 32'd0;
    end else if (state_q == ST_GRANT) begin
      busy_cnt_q <= 32'd0;
    end else if (is_busy) begin
      busy_cnt_q <= busy_cnt_q + 32'd1;
    end
  end

  // Saturating count of aborted transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_cnt_q <= 16'd0;
    end else if (abort_hit && abort_cnt_q != 16'hFFFF) begin
      abort_cnt_q <= abort_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: self-checking bench for sdram_arbiter. The reference
// model works at transaction level: the bench decides which port must be
// served in what order from the round-robin rule, derives every grant, BUSY
// window and completion cycle by arithmetic, plays the SDRAM engine itself,
// and compares the DUT outputs against that timeline every cycle.
module tb_sdram_arbiter;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_start, p0_rnw, p1_start, p1_rnw;
  logic [15:0] p0_wdat, p1_wdat;
  logic        p0_done, p0_ready, p0_abort, p1_done, p1_ready, p1_abort;
  logic [15:0] rdat;
  logic        dram_start, dram_rnw;
  logic [15:0] dram_wdat;
  logic        dram_done, dram_ready;
  logic [15:0] dram_rdat;
  logic [15:0] abort_count;

  sdram_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_start(p0_start), .p0_rnw(p0_rnw), .p0_wdat(p0_wdat),
    .p0_done(p0_done), .p0_ready(p0_ready), .p0_abort(p0_abort),
    .p1_start(p1_start), .p1_rnw(p1_rnw), .p1_wdat(p1_wdat),
    .p1_done(p1_done), .p1_ready(p1_ready), .p1_abort(p1_abort),
    .rdat(rdat),
    .dram_start(dram_start), .dram_rnw(dram_rnw), .dram_wdat(dram_wdat),
    .dram_done(dram_done), .dram_ready(dram_ready), .dram_rdat(dram_rdat),
    .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int last_g;      // port served most recently, as the model sees it
  int exp_aborts;  // expected abort_count

  // Transfer plan: expected service order, direction, engine delay, timeout.
  int n_x;
  int x_port[4];
  bit x_rnw[4];
  int x_d[4];      // BUSY-cycle index at which the transfer ends
  bit x_to[4];
  // Start pulses to apply: cycle, port, direction.
  int n_ev;
  int ev_cyc[6];
  int ev_port[6];
  bit ev_rnw[6];

  function automatic logic [6:0] outs();
    return {dram_start, p0_ready, p1_ready, p0_done, p1_done, p0_abort, p1_abort};
  endfunction

  // Plays the planned start pulses and engine behaviour, checking outputs
  // against the timeline derived from the plan. first_g is the cycle of the
  // first grant; later grants follow at g + d + 4 (BUSY d+1, RELEASE, IDLE).
  task automatic execute(input string name, input int first_g, input bit stale_en);
    int g[4];
    int end_c;
    logic [15:0] wd0, wd1, rd, exp_wd;
    logic [6:0] exp_v, obs_v;
    bit in_busy, is_end, is_to;
    int gi, bp, bidx, dlen;
    wd0 = 16'($urandom);
    wd1 = 16'($urandom);
    g[0] = first_g;
    for (int i = 1; i < n_x; i++) g[i] = g[i-1] + x_d[i-1] + 4;
    end_c = g[n_x-1] + x_d[n_x-1] + 4;
    for (int c = 0; c < end_c; c++) begin
      @(posedge clk); #1;
      p0_wdat  = wd0;
      p1_wdat  = wd1;
      p0_start = 1'b0;
      p1_start = 1'b0;
      p0_rnw   = 1'($urandom_range(0, 1));
      p1_rnw   = 1'($urandom_range(0, 1));
      for (int e = 0; e < n_ev; e++) begin
        if (ev_cyc[e] == c) begin
          if (ev_port[e] == 0) begin p0_start = 1'b1; p0_rnw = ev_rnw[e]; end
          else                 begin p1_start = 1'b1; p1_rnw = ev_rnw[e]; end
        end
      end
      gi = -1; in_busy = 1'b0; bp = 0; bidx = 0; dlen = 0; is_to = 1'b0;
      for (int i = 0; i < n_x; i++) begin
        if (c == g[i]) gi = i;
        if (c > g[i] && c <= g[i] + 1 + x_d[i]) begin
          in_busy = 1'b1; bp = x_port[i]; bidx = c - g[i] - 1;
          dlen = x_d[i]; is_to = x_to[i];
        end
      end
      is_end = in_busy && (bidx == dlen);
      if (in_busy)
        dram_done = is_to ? 1'b0
                          : (is_end || (bidx == 0 && stale_en && $urandom_range(0, 1) == 1));
      else
        dram_done = stale_en && $urandom_range(0, 1) == 1;
      dram_ready = 1'($urandom_range(0, 1));
      rd         = 16'($urandom);
      dram_rdat  = rd;
      exp_v = {gi >= 0,
               in_busy && dram_ready && bp == 0,
               in_busy && dram_ready && bp == 1,
               is_end && bp == 0,
               is_end && bp == 1,
               is_end && is_to && bp == 0,
               is_end && is_to && bp == 1};
      @(negedge clk);
      obs_v = outs();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL %s cyc=%0d outs(start,r0,r1,d0,d1,a0,a1) got=%b exp=%b",
                 name, c, obs_v, exp_v);
      end
      n_cmp++;
      if (rdat !== rd) begin
        n_err++;
        $display("FAIL %s cyc=%0d rdat got=%h exp=%h", name, c, rdat, rd);
      end
      if (gi >= 0) begin
        exp_wd = (x_port[gi] == 1) ? wd1 : wd0;
        n_cmp++;
        if ({dram_rnw, dram_wdat} !== {x_rnw[gi], exp_wd}) begin
          n_err++;
          $display("FAIL %s grant%0d rnw/wdat got=%b/%h exp=%b/%h",
                   name, gi, dram_rnw, dram_wdat, x_rnw[gi], exp_wd);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      p0_start = 1'b1; p1_start = 1'b1;
      p0_rnw = 1'($urandom_range(0, 1)); p1_rnw = 1'($urandom_range(0, 1));
      p0_wdat = 16'($urandom); p1_wdat = 16'($urandom);
      dram_done = 1'b1; dram_ready = 1'b1; dram_rdat = 16'($urandom);
      @(negedge clk);
      n_cmp++;
      if (outs() !== 7'b0) begin
        n_err++;
        $display("FAIL reset_outs cyc=%0d got=%b exp=0", c, outs());
      end
      n_cmp++;
      if (abort_count !== 16'd0) begin
        n_err++;
        $display("FAIL reset_abort_count got=%0d exp=0", abort_count);
      end
    end
    // Starts held during reset must not have been latched.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      rst = 1'b0; p0_start = 1'b0; p1_start = 1'b0; dram_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (dram_start !== 1'b0) begin
        n_err++;
        $display("FAIL reset_start_dropped cyc=%0d got=%b exp=0", c, dram_start);
      end
    end
    last_g = 1;
    exp_aborts = 0;
  endtask

  // Single write from port 0; engine finishes 10 cycles after the start.
  task automatic test_latency();
    n_x = 1; x_port[0] = 0; x_rnw[0] = 1'b0; x_d[0] = 7; x_to[0] = 1'b0;
    n_ev = 1; ev_cyc[0] = 0; ev_port[0] = 0; ev_rnw[0] = 1'b0;
    execute("latency", 2, 1'b1);
    last_g = 0;
  endtask

  // Simultaneous requests straight after reset, three times over.
  task automatic test_back_to_back();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    last_g = 1;
    for (int r = 0; r < 3; r++) begin
      bit r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      n_ev = 2;
      ev_cyc[0] = 0; ev_port[0] = 0; ev_rnw[0] = r0;
      ev_cyc[1] = 0; ev_port[1] = 1; ev_rnw[1] = r1;
      n_x = 2;
      x_port[0] = (last_g == 0) ? 1 : 0;
      x_port[1] = 1 - x_port[0];
      for (int i = 0; i < 2; i++) begin
        x_rnw[i] = (x_port[i] == 0) ? r0 : r1;
        x_d[i]   = int'($urandom_range(1, 6));
        x_to[i]  = 1'b0;
      end
      execute("back_to_back", 2, 1'b1);
      last_g = x_port[1];
    end
  endtask

  // Random request mixes, including a repeated start from a port that is
  // already pending (or being granted), which must not change its direction.
  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int mask, dup_port;
      bit r[2];
      mask = int'($urandom_range(1, 3));
      r[0] = 1'($urandom_range(0, 1));
      r[1] = 1'($urandom_range(0, 1));
      n_ev = 0;
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          ev_cyc[n_ev] = 0; ev_port[n_ev] = p; ev_rnw[n_ev] = r[p]; n_ev++;
        end
      end
      dup_port = (mask == 3) ? int'($urandom_range(0, 1)) : ((mask == 1) ? 0 : 1);
      ev_cyc[n_ev] = int'($urandom_range(1, 2));
      ev_port[n_ev] = dup_port;
      ev_rnw[n_ev] = ~r[dup_port];
      n_ev++;
      if (mask == 3) begin
        n_x = 2;
        x_port[0] = (last_g == 0) ? 1 : 0;
        x_port[1] = 1 - x_port[0];
      end else begin
        n_x = 1;
        x_port[0] = (mask == 1) ? 0 : 1;
      end
      for (int i = 0; i < n_x; i++) begin
        x_rnw[i] = r[x_port[i]];
        x_d[i]   = int'($urandom_range(1, 6));
        x_to[i]  = 1'b0;
      end
      execute("random", 2, 1'b1);
      last_g = x_port[n_x-1];
    end
  endtask

  // Port 0 re-requests during its own BUSY while port 1 also requests:
  // port 1 is served next, then port 0 again with the new direction.
  task automatic test_rearm();
    bit r1;
    r1 = 1'($urandom_range(0, 1));
    n_ev = 3;
    ev_cyc[0] = 0; ev_port[0] = 0; ev_rnw[0] = 1'b0;
    ev_cyc[1] = 4; ev_port[1] = 1; ev_rnw[1] = r1;
    ev_cyc[2] = 4; ev_port[2] = 0; ev_rnw[2] = 1'b1;
    n_x = 3;
    x_port[0] = 0; x_rnw[0] = 1'b0; x_d[0] = 3; x_to[0] = 1'b0;
    x_port[1] = 1; x_rnw[1] = r1;   x_d[1] = 2; x_to[1] = 1'b0;
    x_port[2] = 0; x_rnw[2] = 1'b1; x_d[2] = int'($urandom_range(1, 6)); x_to[2] = 1'b0;
    execute("rearm", 2, 1'b1);
    last_g = 0;
  endtask

  // Port 1 transfer with an engine that never completes.
  task automatic test_timeout();
    n_ev = 1; ev_cyc[0] = 0; ev_port[0] = 1; ev_rnw[0] = 1'($urandom_range(0, 1));
    n_x = 1; x_port[0] = 1; x_rnw[0] = ev_rnw[0]; x_d[0] = TO; x_to[0] = 1'b1;
    execute("timeout", 2, 1'b0);
    last_g = 1;
    exp_aborts++;
    n_cmp++;
    if (abort_count !== 16'(exp_aborts)) begin
      n_err++;
      $display("FAIL timeout_abort_count got=%0d exp=%0d", abort_count, exp_aborts);
    end
  endtask

  // One-cycle reset in the middle of a port 1 transfer.
  task automatic test_reset_mid_busy();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      rst        = (c == 5);
      p1_start   = (c == 0);
      p1_rnw     = 1'b1;
      p0_start   = (c == 5);
      dram_done  = (c >= 5);
      dram_ready = (c >= 5);
      @(negedge clk);
      if (c == 2) begin
        n_cmp++;
        if (dram_start !== 1'b1) begin
          n_err++;
          $display("FAIL midrst_grant got=%b exp=1", dram_start);
        end
      end
      if (c >= 5) begin
        n_cmp++;
        if (outs() !== 7'b0) begin
          n_err++;
          $display("FAIL midrst_outs cyc=%0d got=%b exp=0", c, outs());
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (abort_count !== 16'd0) begin
          n_err++;
          $display("FAIL midrst_abort_count got=%0d exp=0", abort_count);
        end
      end
    end
    last_g = 1;
    exp_aborts = 0;
    n_ev = 1; ev_cyc[0] = 0; ev_port[0] = 0; ev_rnw[0] = 1'b0;
    n_x = 1; x_port[0] = 0; x_rnw[0] = 1'b0; x_d[0] = 4; x_to[0] = 1'b0;
    execute("after_reset", 2, 1'b1);
    last_g = 0;
  endtask

  initial begin
    rst = 1'b1;
    p0_start = 1'b0; p1_start = 1'b0; p0_rnw = 1'b0; p1_rnw = 1'b0;
    p0_wdat = 16'd0; p1_wdat = 16'd0;
    dram_done = 1'b0; dram_ready = 1'b0; dram_rdat = 16'd0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_random();
    test_rearm();
    test_timeout();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16777216, BUSY-state cycles before a transfer is aborted.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 p0_start, p1_start  in  1 each  one-cycle request pulse from port 0 / port 1.
REQ-005 p0_rnw, p1_rnw  in  1 each  direction for the request, sampled with pN_start (1 = read).
REQ-006 p0_wdat, p1_wdat  in  16 each  write data per port.
REQ-007 p0_done, p1_done  out  1 each  transfer-complete pulse to the owning port.
REQ-008 p0_ready, p1_ready  out  1 each  per-word strobe to the owning port.
REQ-009 p0_abort, p1_abort  out  1 each  high together with pN_done when a transfer timed out.
REQ-010 rdat  out  16  read data, broadcast to both ports.
REQ-011 dram_start  out  1  start pulse to the SDRAM engine.
REQ-012 dram_rnw  out  1  direction to the engine.
REQ-013 dram_wdat  out  16  write data to the engine.
REQ-014 dram_done, dram_ready  in  1 each  engine completion level and word strobe.
REQ-015 dram_rdat  in  16  engine read data.
REQ-016 abort_count  out  16  saturating count of timed-out transfers.

Function
REQ-017 Each port SHALL have a pending flag and a latched rnw bit; pN_start sets the flag and captures pN_rnw on the next edge.
REQ-018 A pN_start arriving while that port's flag is already set SHALL be ignored, and the latched rnw SHALL be kept.
REQ-019 FSM states SHALL be IDLE, GRANT, BUSY and RELEASE.
REQ-020 IDLE -> GRANT when any flag is set; the granted port is recorded in a grant register.
REQ-021 GRANT lasts one cycle, with dram_start=1 and dram_rnw equal to the latched rnw; GRANT -> BUSY.
REQ-022 BUSY -> RELEASE on the first cycle dram_done=1, provided BUSY has lasted at least 2 cycles; earlier dram_done SHALL be ignored as the stale idle level.
REQ-023 RELEASE lasts one cycle, clears the granted port's pending flag, then -> IDLE.
REQ-024 Latency: a start sampled in IDLE with no other pending request SHALL give dram_start=1 exactly 2 cycles later.
REQ-025 Arbitration SHALL be round-robin: with both flags set in IDLE, the port not granted last SHALL win; the last-grant register resets to port 1, so port 0 wins first.
REQ-026 A port's new pN_start during its own BUSY SHALL set its flag; after RELEASE the other pending port still wins.
REQ-027 pN_ready = dram_ready AND (state==BUSY) AND (grant==N), combinational.
REQ-028 pN_done = dram_done AND (state==BUSY) AND (grant==N), qualified as in REQ-022.
REQ-029 dram_wdat SHALL be a combinational mux of p0_wdat/p1_wdat selected by the grant register.
REQ-030 rdat SHALL equal dram_rdat, combinational.
REQ-031 A 32-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-032 On reaching TIMEOUT, the FSM SHALL force BUSY -> RELEASE and pulse pN_done and pN_abort for one cycle.
REQ-033 On timeout, abort_count SHALL increment, holding at 0xFFFF.
REQ-034 The non-granted port SHALL never see ready, done or abort.

Reset
REQ-035 While rst=1: state = IDLE.
REQ-036 While rst=1: both pending flags = 0.
REQ-037 While rst=1: last-grant = 1.
REQ-038 While rst=1: the timeout counter = 0.
REQ-039 While rst=1: dram_start, all pN_done, pN_ready and pN_abort outputs = 0.
REQ-040 While rst=1: abort_count = 0.
REQ-041 rst asserted mid-transfer SHALL abandon the transfer without emitting pN_done, and starts during rst SHALL be dropped.

Verification
REQ-042 p0_start, p0_rnw=0 at cycle 10 -> dram_start=1 only at cycle 12 with dram_rnw=0, dram_wdat=p0_wdat.
REQ-043 Engine raises dram_done at cycle 20 -> p0_done=1 at cycle 20, p1_done=0, and IDLE by cycle 22.
REQ-044 p0_start and p1_start in the same cycle after reset -> port 0 served first, then port 1; three repeats alternate 0,1,0,1,0,1.
REQ-045 TIMEOUT=100 with dram_done held 0 -> p1_done=p1_abort=1 exactly 100 BUSY cycles after entry, and abort_count=1.
REQ-046 rst pulsed for 1 cycle during BUSY of port 1 -> no p1_done, all outputs 0, and the next p0_start is served normally.
REQ-047 Second p0_start while p0 pending in IDLE/GRANT -> exactly one transfer, with the first rnw.
